// File: rtl/blink_sequencer.sv
`timescale 1ns/1ps
// blink_sequencer
//   Command-driven blink controller. A pattern command (on-time, off-time,
//   repeat count) is taken over a valid/ready handshake. The block then drives
//   the registered blink line through the requested number of on/off pulses.
//   When the pattern finishes, it returns to idle with a one-cycle done pulse.
//   A repeat count of 0 runs the pattern until abort or reset.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready  command handshake; ready = idle && !abort
//   cmd_on_cycles    high-phase length in cycles (0 treated as 1)
//   cmd_off_cycles   low-phase length in cycles (0 treated as 1)
//   cmd_repeat       pulse count (0 = continuous)
//   abort            stop the current pattern on the next edge, no done
//   blink            registered blink output
//   busy             pattern in progress
//   done             one-cycle pulse on normal completion
//   pulse_cnt        completed pulses of the current or last command
module blink_sequencer #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_on_cycles,
  input  logic [CNT_W-1:0] cmd_off_cycles,
  input  logic [REP_W-1:0] cmd_repeat,
  input  logic             abort,
  output logic             blink,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] on_len;
  logic [CNT_W-1:0] off_len;
  logic [REP_W-1:0] rep;
  logic [CNT_W-1:0] on_clamp;
  logic [CNT_W-1:0] off_clamp;
  logic [REP_W-1:0] pulse_next;
  logic             accept;

  // A zero-length phase is stretched to one cycle so the FSM always advances.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
    return (len == '0) ? CNT_W'(1) : len;
  endfunction

  // Abort blocks acceptance even in idle, so it wins over a simultaneous command.
  assign cmd_ready  = (state == IDLE) && !abort;
  assign accept     = cmd_valid && cmd_ready;
  assign on_clamp   = clamp_len(cmd_on_cycles);
  assign off_clamp  = clamp_len(cmd_off_cycles);
  assign pulse_next = pulse_cnt + REP_W'(1);

  // Latched pattern parameters: written only on accept, stable for the whole pattern.
  always_ff @(posedge clk) begin
    if (accept) begin
      on_len  <= on_clamp;
      off_len <= off_clamp;
      rep     <= cmd_repeat;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase_cnt <= '0;
      blink     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            phase_cnt <= on_clamp - CNT_W'(1);
            pulse_cnt <= '0;
            blink     <= 1'b1;
            busy      <= 1'b1;
            state     <= ON;
          end
        end
        ON: begin
          if (abort) begin
            blink <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (phase_cnt == '0) begin
            phase_cnt <= off_len - CNT_W'(1);
            blink     <= 1'b0;
            state     <= OFF;
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end
        OFF: begin
          if (phase_cnt == '0) begin
            // The pulse is counted even if abort arrives on this very edge.
            pulse_cnt <= pulse_next;
            if (abort) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else if ((rep != '0) && (pulse_next == rep)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              phase_cnt <= on_len - CNT_W'(1);
              blink     <= 1'b1;
              state     <= ON;
            end
          end else if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end
        default: begin
          blink <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blink_sequencer.sv
`timescale 1ns/1ps
// Testbench for blink_sequencer. Stimulus pushes expected per-cycle outputs
// (keyed by cycle) into a scoreboard queue; a negedge monitor pops and
// compares them. Expected values follow the pattern timing of the block:
// accept at edge A, cycle c lies between edges A+c-1 and A+c.
module tb_blink_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_on_cycles;
  logic [15:0] cmd_off_cycles;
  logic [7:0]  cmd_repeat;
  logic        abort;
  logic        blink;
  logic        busy;
  logic        done;
  logic [7:0]  pulse_cnt;

  blink_sequencer #(.CNT_W(16), .REP_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_on_cycles  (cmd_on_cycles),
    .cmd_off_cycles (cmd_off_cycles),
    .cmd_repeat     (cmd_repeat),
    .abort          (abort),
    .blink          (blink),
    .busy           (busy),
    .done           (done),
    .pulse_cnt      (pulse_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [11:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];

  function automatic logic [11:0] pack(input logic b, input logic bs, input logic d,
                                       input logic r, input logic [7:0] p);
    return {b, bs, d, r, p};
  endfunction

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got blink=%b busy=%b done=%b ready=%b pcnt=%0d, expected blink=%b busy=%b done=%b ready=%b pcnt=%0d",
               nm, edge_n, act[11], act[10], act[9], act[8], act[7:0],
               exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic push(input int cyc, input logic b, input logic bs, input logic d,
                      input logic r, input logic [7:0] p, input string nm);
    exp_t e;
    e.cyc = cyc;
    e.v   = pack(b, bs, d, r, p);
    e.nm  = nm;
    sb.push_back(e);
  endtask

  // Expected outputs for cycles 1..last_c of a pattern accepted at edge a.
  task automatic gen(input int a, input int n, input int m, input int r,
                     input int last_c, input string nm);
    int per;
    per = n + m;
    for (int c = 1; c <= last_c; c++) begin
      if (r != 0 && c > r * per)
        push(a + c - 1, 1'b0, 1'b0, (c == r * per + 1), 1'b1, 8'(r), nm);
      else
        push(a + c - 1, (((c - 1) % per) < n), 1'b1, 1'b0, 1'b0, 8'((c - 1) / per), nm);
    end
  endtask

  // Monitor: compares the scoreboard entry belonging to the current cycle.
  exp_t me;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < edge_n) begin
      me = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expected entry for edge %0d never sampled (now %0d)", me.nm, me.cyc, edge_n);
    end
    if (sb.size() > 0 && sb[0].cyc == edge_n) begin
      me = sb.pop_front();
      check(me.nm, pack(blink, busy, done, cmd_ready, pulse_cnt), me.v);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int tgt);
    while (edge_n < tgt) step();
  endtask

  // Presents a command; returns the edge on which it will be accepted.
  task automatic send(input logic [15:0] on_c, input logic [15:0] off_c,
                      input logic [7:0] rep_c, output int a);
    cmd_valid      = 1'b1;
    cmd_on_cycles  = on_c;
    cmd_off_cycles = off_c;
    cmd_repeat     = rep_c;
    a = edge_n + 1;
  endtask

  // Drops valid after the accepting edge and scrambles the fields.
  task automatic release_cmd();
    step();
    cmd_valid      = 1'b0;
    cmd_on_cycles  = 16'hFFFF;
    cmd_off_cycles = 16'hFFFF;
    cmd_repeat     = 8'hAA;
  endtask

  initial begin
    #(100000 * 20);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int a;
  int e0;

  initial begin
    rst            = 1'b1;
    cmd_valid      = 1'b0;
    cmd_on_cycles  = '0;
    cmd_off_cycles = '0;
    cmd_repeat     = '0;
    abort          = 1'b0;
    step();
    step();
    check("reset_state", pack(blink, busy, done, cmd_ready, pulse_cnt), pack(0, 0, 0, 1, 8'd0));
    rst = 1'b0;
    push(edge_n, 0, 0, 0, 1, 8'd0, "idle_after_reset");
    step();
    step();

    // Basic pattern: on=3 off=2 repeat=2
    send(16'd3, 16'd2, 8'd2, a);
    gen(a, 3, 2, 2, 13, "basic");
    release_cmd();
    wait_until(a + 13);

    // Zero clamping: on=0 off=0 repeat=3
    send(16'd0, 16'd0, 8'd3, a);
    gen(a, 1, 1, 3, 8, "clamp");
    release_cmd();
    wait_until(a + 8);

    // Continuous mode, abort sampled at the end of cycle 9
    send(16'd1, 16'd1, 8'd0, a);
    gen(a, 1, 1, 0, 9, "cont");
    push(a + 9, 0, 0, 0, 1, 8'd4, "cont_abort");
    push(a + 10, 0, 0, 0, 1, 8'd4, "cont_idle");
    release_cmd();
    wait_until(a + 8);
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_until(a + 11);

    // Back-pressure then back-to-back: second command held during the first
    send(16'd2, 16'd1, 8'd2, a);
    gen(a, 2, 1, 2, 7, "bp_first");
    gen(a + 7, 1, 2, 1, 5, "b2b_second");
    step();
    cmd_on_cycles  = 16'd1;
    cmd_off_cycles = 16'd2;
    cmd_repeat     = 8'd1;
    wait_until(a + 7);
    cmd_valid = 1'b0;
    wait_until(a + 12);

    // Abort together with cmd_valid in idle: no accept
    e0 = edge_n;
    cmd_valid      = 1'b1;
    cmd_on_cycles  = 16'd4;
    cmd_off_cycles = 16'd4;
    cmd_repeat     = 8'd1;
    abort          = 1'b1;
    push(e0, 0, 0, 0, 0, 8'd1, "abort_idle_block");
    push(e0 + 1, 0, 0, 0, 1, 8'd1, "abort_idle_noaccept");
    push(e0 + 2, 0, 0, 0, 1, 8'd1, "abort_idle_stay");
    step();
    cmd_valid = 1'b0;
    abort     = 1'b0;
    wait_until(e0 + 3);

    // Abort on the final OFF-expiry edge: no done, count still advances
    send(16'd1, 16'd2, 8'd2, a);
    gen(a, 1, 2, 2, 6, "abort_final");
    push(a + 6, 0, 0, 0, 1, 8'd2, "abort_final_nodone");
    push(a + 7, 0, 0, 0, 1, 8'd2, "abort_final_hold");
    release_cmd();
    wait_until(a + 5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_until(a + 8);

    // Asynchronous reset in the middle of an ON phase
    send(16'd2, 16'd1, 8'd0, a);
    gen(a, 2, 1, 0, 7, "rst_run");
    push(a + 8, 0, 0, 0, 1, 8'd0, "rst_idle1");
    push(a + 9, 0, 0, 0, 1, 8'd0, "rst_idle2");
    release_cmd();
    wait_until(a + 7);
    check("rst_pre", pack(blink, busy, done, cmd_ready, pulse_cnt), pack(1, 1, 0, 0, 8'd2));
    #2 rst = 1'b1;
    #1 check("rst_async", pack(blink, busy, done, cmd_ready, pulse_cnt), pack(0, 0, 0, 1, 8'd0));
    #2 rst = 1'b0;
    #1 check("rst_release", pack(blink, busy, done, cmd_ready, pulse_cnt), pack(0, 0, 0, 1, 8'd0));
    wait_until(a + 10);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 50 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d scoreboard entries left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_sequencer.md
# blink_sequencer

Command-driven controller for the board blink output. It accepts a pattern command over a valid/ready handshake, with on-time, off-time and repeat count. It then drives a registered `blink` line through that many on/off pulses, and returns to idle with a one-cycle `done` pulse. It sits between the control/CSR logic and the LED pin and replaces a free-running blinker when software needs patterned or counted blinks.

## Interface
- `CNT_W`, 16, width of the on/off phase-length fields (cycles).
- `REP_W`, 8, width of the repeat count and pulse counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_on_cycles`  in  CNT_W  length of each high phase in cycles; 0 treated as 1.
- `cmd_off_cycles`  in  CNT_W  length of each low phase in cycles; 0 treated as 1.
- `cmd_repeat`  in  REP_W  number of pulses; 0 = continuous until abort.
- `abort`  in  1  stop the current pattern immediately.
- `blink`  out  1  registered blink output.
- `busy`  out  1  pattern in progress (state != IDLE).
- `done`  out  1  one-cycle pulse on normal completion.
- `pulse_cnt`  out  REP_W  completed pulses of the current or last command.

## Operation
- **FSM states:** IDLE, ON, OFF.
- **Reset values:** state=IDLE, `blink`=0, `busy`=0, `done`=0, `pulse_cnt`=0, `cmd_ready`=1. Reset is asynchronous and takes effect mid-pattern with no completion pulse.
- **`cmd_ready`:** equals (state==IDLE) && !`abort`, combinational. A command is accepted on an edge where `cmd_valid` && `cmd_ready`.
- **On accept:**
  - Latch on_len = max(`cmd_on_cycles`,1), off_len = max(`cmd_off_cycles`,1) and rep = `cmd_repeat`.
  - Clear `pulse_cnt`.
  - Load the phase counter with on_len-1 and go to ON.
  - Command fields are ignored when not accepted.
- **ON:** `blink`=1. The phase counter counts down. At 0, load off_len-1 and go to OFF.
- **OFF:** `blink`=0. At phase counter 0, increment `pulse_cnt` (wraps modulo 2^REP_W). Then:
  - If rep != 0 and the new `pulse_cnt` == rep: go to IDLE and assert `done` for one cycle.
  - Otherwise: load on_len-1 and go to ON.
- **Continuous mode (rep=0):** never completes. `pulse_cnt` wraps. Exit only via abort or reset.
- **`abort`:**
  - In ON/OFF, `abort` sampled high moves the FSM to IDLE on that edge. `blink`=0 from the next cycle, with no `done`. `pulse_cnt` holds its current value.
  - In IDLE, `abort` only blocks acceptance for that cycle. Abort has priority over a simultaneous `cmd_valid`, and the command is not consumed.
  - Abort coinciding with the final OFF-phase expiry: abort wins, so no `done` is produced, but the `pulse_cnt` increment still occurs.
- **Latched parameters:** a command presented while busy is held off (`cmd_ready`=0). Latched parameters never change mid-pattern.
- **Output registers:** `blink`, `busy`, `done` and `pulse_cnt` are all registered outputs.

## Timing
- Let accept occur at edge 0, with on=N and off=M.
- `blink`=1 in cycles 1..N and 0 in cycles N+1..N+M, then repeats with period N+M.
- Pulse k completes at edge k(N+M). `pulse_cnt`=k is visible in the following cycle.
- On the final pulse R:
  - `done`=1, `busy`=0 and `cmd_ready`=1 in cycle R(N+M)+1.
  - A new command may be accepted in that same cycle. Its first high cycle is R(N+M)+2, giving back-to-back patterns with exactly one idle low cycle between them.
- `busy` is high in cycles 1..R(N+M).
- Accept-to-first-high latency is 1 cycle. Abort-to-`blink`-low latency is 1 cycle.
- Phase counter width is CNT_W. The maximum phase is 2^CNT_W-1 cycles.

## Test plan
- **Basic pattern:** reset, then on=3, off=2, repeat=2 accepted at cycle 0 → `blink` high cycles 1-3 and 6-8, low 4-5 and 9-10. `done`=1 only in cycle 11. `pulse_cnt`=2 from cycle 11 and held afterwards.
- **Zero clamping:** on=0, off=0, repeat=3 → `blink` toggles 1,0,1,0,1,0 in cycles 1-6. `done` in cycle 7.
- **Continuous mode with abort:** repeat=0, on=1, off=1, abort asserted at cycle 9 → `blink`=0 from cycle 10. No `done`. `pulse_cnt`=4. `cmd_ready`=1 from cycle 10.
- **Back-pressure and back-to-back:**
  - `cmd_valid` held high during a busy pattern → `cmd_ready`=0 throughout and the command is not consumed.
  - The second command is accepted in the `done` cycle, and its `blink` rises the next cycle.
- **Simultaneous events:**
  - `abort` with `cmd_valid` in IDLE → no accept, `busy` stays 0.
  - `abort` on the final OFF-expiry edge → no `done`, `pulse_cnt` incremented.
- **Asynchronous reset mid-ON:** `rst` pulsed between clock edges → `blink`, `busy`, `done` and `pulse_cnt` go to 0 immediately without waiting for a clock edge. `cmd_ready`=1 after release.
